esp_dma64_mem_responder: RTL and testbench
==========================================

# esp_dma64_mem_responder

Memory-backed responder for the 64-bit ESP accelerator DMA interface. It accepts read and write requests on the dma_read_ctrl and dma_write_ctrl channels and serves them from a local word-addressed memory. Read data is streamed out on dma_read_chnl, and write data is absorbed from dma_write_chnl. It sits on the far side of an accelerator's DMA ports, or of the axi2dmafifo bridge, and serves as the standalone memory model and on-chip scratchpad target for the traffic-generator accelerators.

## Interface
- MEM_WORDS, 1024: memory depth in 64-bit words; power of two.
- AW, $clog2(MEM_WORDS): internal word-address width.
- clk  input  1  sole clock.
- rst  input  1  reset; synchronous, active-high.
- dma_read_ctrl_valid  input  1  read request valid.
- dma_read_ctrl_ready  output  1  read request accepted.
- dma_read_ctrl_data_index  input  32  start word index.
- dma_read_ctrl_data_length  input  32  burst length in words.
- dma_read_ctrl_data_size  input  3  beat size code; 3'b011 is the only legal value.
- dma_read_chnl_valid  output  1  read beat valid.
- dma_read_chnl_ready  input  1  read beat consumed.
- dma_read_chnl_data  output  64  read beat.
- dma_write_ctrl_valid / _ready / _data_index / _data_length / _data_size: same widths and meaning as the read control channel, for writes.
- dma_write_chnl_valid  input  1  write beat valid.
- dma_write_chnl_ready  output  1  write beat accepted.
- dma_write_chnl_data  input  64  write beat.
- busy  output  1  high in any state other than IDLE.
- err  output  1  sticky error flag; cleared only by rst.
- debug  output  32  {16-bit completed-burst count, 16-bit count of beats left in the current burst}.

## Operation
- FSM states:
  - IDLE: waits for a control request.
  - RD: streams a read burst.
  - WR: absorbs a write burst.
- Arbitration in IDLE:
  - Round-robin between read and write; only the granted channel's ctrl_ready is asserted in a given cycle.
  - After reset the read channel is preferred.
  - When only one valid is present, that channel is granted regardless of the last grant.
- On a control handshake, index[AW-1:0] and length are latched and the FSM enters RD or WR.
- Length 0: the handshake completes, no data beats are produced or accepted, the FSM stays in IDLE, and the burst count increments.
- RD: emits `length` beats from addresses index, index+1, ...; addresses wrap modulo MEM_WORDS.
- WR: writes each accepted beat to the current address, then increments the address with the same wrap rule.
- After the last beat is transferred, the FSM returns to IDLE and the burst count increments.
- err is set on a control handshake when either condition holds:
  - size is not 3'b011; the request is still served as 64-bit.
  - index+length exceeds MEM_WORDS; the request is still served with wrap.
- The burst counter saturates at 16'hFFFF.
- Memory contents are not reset.

## Timing
- Reset values:
  - Outputs: all ready and valid outputs 0, busy 0, err 0, debug 0, dma_read_chnl_data 0.
  - Internal: state IDLE, round-robin pointer set to read.
- Both ctrl_ready outputs are 0 outside IDLE; a control handshake happens in the same cycle valid and ready are both high.
- Read path, for a handshake in cycle N:
  - The first beat is valid in cycle N+2.
  - With dma_read_chnl_ready held high, one beat is transferred per cycle.
  - valid and data hold stable while ready is low; a beat transfers when valid and ready are both high.
- Write path, for a handshake in cycle N:
  - dma_write_chnl_ready is high from N+1 until the cycle of the last beat, inclusive.
  - A write-enabled beat is committed to memory in the cycle it is accepted.
- Return to IDLE: the cycle after the last beat transfer, the FSM is in IDLE and can accept a new control request in that same cycle.
- Back-to-back minimum is therefore 1 idle cycle between bursts.
- Read-after-write: a read issued right after a write burst returns the new data.
- rst asserted mid-burst:
  - The FSM returns to IDLE on the next edge and the burst is abandoned.
  - Memory contents already written are kept.
  - Remaining beats are neither produced nor accepted.

## Configuration
- DMA_RESP_STALL_EN: when defined, a 16-bit LFSR (seed 16'hACE1, reset by rst) randomly gates the data channels.
  - Read: dma_read_chnl_valid is suppressed on cycles where the LFSR bit 0 is 1. A beat already presented with valid high stays valid until it is taken.
  - Write: dma_write_chnl_ready is deasserted on the same LFSR condition.
- When not defined, the data channels run at full throughput as specified under Timing.

## Test plan
- Write then read back:
  - Stimulus: write index 0, length 4, data 64'h1..64'h4; then read index 0, length 4, with chnl_ready held high.
  - Required: read beats 1,2,3,4 in cycles N+2..N+5, err=0, debug[31:16]=2.
- Read backpressure: read with length 3 while toggling dma_read_chnl_ready 1-0-1-0 -> data holds during ready-low cycles, exactly 3 beats are transferred, and busy drops the cycle after the third.
- Wrap and error: with MEM_WORDS=1024, write index 1022, length 4 -> the beats land at addresses 1022, 1023, 0, 1, and err=1 after the handshake.
- Simultaneous requests: read and write valid in the same cycle straight after reset -> the read is granted first; after it completes with both still valid, the write is granted.
- Length 0 and illegal size:
  - Read with length 0 -> no chnl_valid is produced, the next request is accepted in the following cycle, and the burst count increments.
  - A request with size 3'b010 -> err=1 and the request is still served as 64-bit.
- Reset mid-burst: assert rst during beat 2 of an 8-beat read -> all outputs take their reset values on the next edge; a following 1-beat read is served normally.

Source files
------------

// File: rtl/esp_dma64_mem_responder.sv
// Memory-backed responder for the 64-bit ESP DMA read/write channels.
// Optional `DMA_RESP_STALL_EN` adds LFSR-driven stalls on the data channels.
module esp_dma64_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_read_ctrl_valid,
  output logic        dma_read_ctrl_ready,
  input  logic [31:0] dma_read_ctrl_data_index,
  input  logic [31:0] dma_read_ctrl_data_length,
  input  logic [2:0]  dma_read_ctrl_data_size,
  output logic        dma_read_chnl_valid,
  input  logic        dma_read_chnl_ready,
  output logic [63:0] dma_read_chnl_data,
  input  logic        dma_write_ctrl_valid,
  output logic        dma_write_ctrl_ready,
  input  logic [31:0] dma_write_ctrl_data_index,
  input  logic [31:0] dma_write_ctrl_data_length,
  input  logic [2:0]  dma_write_ctrl_data_size,
  input  logic        dma_write_chnl_valid,
  output logic        dma_write_chnl_ready,
  input  logic [63:0] dma_write_chnl_data,
  output logic        busy,
  output logic        err,
  output logic [31:0] debug
);

  // state | meaning
  // IDLE  | arbitrating control requests
  // RD    | streaming a read burst
  // WR    | absorbing a write burst
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_mem [MEM_WORDS];
  logic [AW-1:0] r_addr;
  logic [31:0] r_beats_left;
  logic [31:0] r_issue_left;
  logic [63:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_pref_rd;
  logic        r_err;
  logic [15:0] r_burst_cnt;

  logic        w_stall;
  logic        w_idle, w_grant_rd, w_grant_wr, w_hs;
  logic [31:0] w_idx, w_len;
  logic [2:0]  w_size;
  logic [32:0] w_end;
  logic        w_bad_req;
  logic        w_fetch, w_rd_xfer, w_wr_xfer, w_xfer, w_last, w_cnt_inc;

`ifdef DMA_RESP_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  // Round-robin: a lone requester always wins; otherwise the preferred side does.
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign w_grant_rd = w_idle && dma_read_ctrl_valid && (!dma_write_ctrl_valid || r_pref_rd);
  assign w_grant_wr = w_idle && dma_write_ctrl_valid && !w_grant_rd;
  assign w_hs       = w_grant_rd || w_grant_wr;

  assign w_idx  = w_grant_rd ? dma_read_ctrl_data_index  : dma_write_ctrl_data_index;
  assign w_len  = w_grant_rd ? dma_read_ctrl_data_length : dma_write_ctrl_data_length;
  assign w_size = w_grant_rd ? dma_read_ctrl_data_size   : dma_write_ctrl_data_size;
  assign w_end     = {1'b0, w_idx} + {1'b0, w_len};
  assign w_bad_req = (w_size != 3'b011) || (w_end > 33'(MEM_WORDS));

  // Prefetch the next beat whenever the output register is empty or being drained.
  assign w_fetch   = (r_state == S_RD) && (r_issue_left != 32'd0) &&
                     (!r_rd_valid || dma_read_chnl_ready) && !w_stall;
  assign w_rd_xfer = r_rd_valid && dma_read_chnl_ready;
  assign dma_write_chnl_ready = (r_state == S_WR) && !rst && !w_stall;
  assign w_wr_xfer = dma_write_chnl_valid && dma_write_chnl_ready;
  assign w_xfer    = w_rd_xfer || w_wr_xfer;
  assign w_last    = w_xfer && (r_beats_left == 32'd1);
  assign w_cnt_inc = (w_hs && (w_len == 32'd0)) || w_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_hs && (w_len != 32'd0)) w_state_nxt = w_grant_rd ? S_RD : S_WR;
      S_RD,
      S_WR:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_beats_left <= '0;
      r_issue_left <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_pref_rd    <= 1'b1;
      r_err        <= 1'b0;
      r_burst_cnt  <= '0;
    end else begin
      if (w_hs) begin
        r_pref_rd    <= w_grant_wr;
        r_addr       <= w_idx[AW-1:0];
        r_beats_left <= w_len;
        r_issue_left <= w_len;
        if (w_bad_req) r_err <= 1'b1;
      end
      if (w_fetch) begin
        r_rd_data    <= r_mem[r_addr];
        r_addr       <= r_addr + 1'b1;
        r_issue_left <= r_issue_left - 32'd1;
      end
      if (w_fetch)        r_rd_valid <= 1'b1;
      else if (w_rd_xfer) r_rd_valid <= 1'b0;
      if (w_xfer) r_beats_left <= r_beats_left - 32'd1;
      if (w_wr_xfer) r_addr <= r_addr + 1'b1;
      if (w_cnt_inc && (r_burst_cnt != 16'hFFFF)) r_burst_cnt <= r_burst_cnt + 16'd1;
    end
  end

  // Storage has no reset so it survives an abandoned burst.
  always_ff @(posedge clk) begin
    if (w_wr_xfer) r_mem[r_addr] <= dma_write_chnl_data;
  end

  assign dma_read_ctrl_ready  = w_grant_rd;
  assign dma_write_ctrl_ready = w_grant_wr;
  assign dma_read_chnl_valid  = r_rd_valid;
  assign dma_read_chnl_data   = r_rd_data;
  assign busy  = (r_state != S_IDLE);
  assign err   = r_err;
  assign debug = {r_burst_cnt, r_beats_left[15:0]};

endmodule

// File: tb/tb_esp_dma64_mem_responder.sv
// Self-checking bench for esp_dma64_mem_responder: directed scenarios plus
// randomized bursts compared against an array-based memory model.
module tb_esp_dma64_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_ctrl_valid = 1'b0, rd_ctrl_ready;
  logic [31:0] rd_ctrl_index = '0, rd_ctrl_length = '0;
  logic [2:0]  rd_ctrl_size = 3'b011;
  logic        rd_chnl_valid, rd_chnl_ready = 1'b0;
  logic [63:0] rd_chnl_data;
  logic        wr_ctrl_valid = 1'b0, wr_ctrl_ready;
  logic [31:0] wr_ctrl_index = '0, wr_ctrl_length = '0;
  logic [2:0]  wr_ctrl_size = 3'b011;
  logic        wr_chnl_valid = 1'b0, wr_chnl_ready;
  logic [63:0] wr_chnl_data = '0;
  logic        busy, err;
  logic [31:0] debug;

  esp_dma64_mem_responder #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .dma_read_ctrl_valid(rd_ctrl_valid), .dma_read_ctrl_ready(rd_ctrl_ready),
    .dma_read_ctrl_data_index(rd_ctrl_index), .dma_read_ctrl_data_length(rd_ctrl_length),
    .dma_read_ctrl_data_size(rd_ctrl_size),
    .dma_read_chnl_valid(rd_chnl_valid), .dma_read_chnl_ready(rd_chnl_ready),
    .dma_read_chnl_data(rd_chnl_data),
    .dma_write_ctrl_valid(wr_ctrl_valid), .dma_write_ctrl_ready(wr_ctrl_ready),
    .dma_write_ctrl_data_index(wr_ctrl_index), .dma_write_ctrl_data_length(wr_ctrl_length),
    .dma_write_ctrl_data_size(wr_ctrl_size),
    .dma_write_chnl_valid(wr_chnl_valid), .dma_write_chnl_ready(wr_chnl_ready),
    .dma_write_chnl_data(wr_chnl_data),
    .busy(busy), .err(err), .debug(debug)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  logic [63:0] m_mem [1024];
  bit          m_known [1024];
  logic        m_err = 1'b0;
  logic [15:0] m_bursts = '0;

  logic [63:0] wr_buf [16];
  logic [63:0] rd_q [$];
  int          rd_cyc_q [$];
  int          hold_err;
  int          wr_starts [$];

  function automatic bit req_bad(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] size);
    return (size != 3'b011) || (({1'b0, idx} + {1'b0, len}) > 33'd1024);
  endfunction

  function automatic int waddr(input logic [31:0] idx, input int i);
    return (int'(idx[9:0]) + i) & 1023;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    rd_ctrl_valid = 0; wr_ctrl_valid = 0; wr_chnl_valid = 0; rd_chnl_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_err = 1'b0;
    m_bursts = '0;
  endtask

  task automatic do_ctrl(input bit is_rd, input logic [31:0] idx, input logic [31:0] len,
                         input logic [2:0] size, output int hs, output bit to);
    int n = 0;
    bit done = 0;
    hs = -1; to = 0;
    while (!done) begin
      @(negedge clk);
      wr_chnl_valid = 0;
      rd_ctrl_valid = is_rd;  wr_ctrl_valid = !is_rd;
      rd_ctrl_index = idx;    wr_ctrl_index = idx;
      rd_ctrl_length = len;   wr_ctrl_length = len;
      rd_ctrl_size = size;    wr_ctrl_size = size;
      #1;
      if (is_rd ? rd_ctrl_ready : wr_ctrl_ready) begin
        done = 1; hs = cyc;
      end else begin
        n++;
        if (n > 50) begin to = 1; done = 1; end
      end
    end
    if (!to) begin
      if (req_bad(idx, len, size)) m_err = 1'b1;
      if (m_bursts != 16'hFFFF) m_bursts = m_bursts + 16'd1;
    end
  endtask

  task automatic wr_beats(input int len, input int mode, output int first_rdy, output bit to);
    int i = 0;
    int budget = 0;
    first_rdy = -1; to = 0;
    while (i < len && !to) begin
      @(negedge clk);
      rd_ctrl_valid = 0; wr_ctrl_valid = 0;
      wr_chnl_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      wr_chnl_data = wr_buf[i];
      #1;
      if (wr_chnl_ready && first_rdy < 0) first_rdy = cyc;
      if (wr_chnl_valid && wr_chnl_ready) i++;
      budget++;
      if (budget > 200) to = 1;
    end
  endtask

  task automatic collect_rd(input int len, input int mode, output bit to);
    int k = 0;
    bit hold = 0;
    logic [63:0] held = '0;
    to = 0;
    rd_q.delete(); rd_cyc_q.delete(); hold_err = 0;
    while (rd_q.size() < len && !to) begin
      @(negedge clk);
      rd_ctrl_valid = 0; wr_ctrl_valid = 0; wr_chnl_valid = 0;
      rd_chnl_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : ($urandom_range(0, 2) != 0);
      #1;
      if (hold && (!rd_chnl_valid || rd_chnl_data !== held)) hold_err++;
      hold = rd_chnl_valid && !rd_chnl_ready;
      held = rd_chnl_data;
      if (rd_chnl_valid && rd_chnl_ready) begin
        rd_q.push_back(rd_chnl_data);
        rd_cyc_q.push_back(cyc);
      end
      k++;
      if (k > 200) to = 1;
    end
  endtask

  task automatic model_write(input logic [31:0] idx, input int len);
    for (int i = 0; i < len; i++) begin
      m_mem[waddr(idx, i)] = wr_buf[i];
      m_known[waddr(idx, i)] = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rd_ctrl_valid = 1; wr_ctrl_valid = 1;
    #1;
    n_checks++; if (rd_ctrl_ready !== 0 || wr_ctrl_ready !== 0) begin n_errors++; $display("FAIL reset_ctrl_ready: got %b%b want 00", rd_ctrl_ready, wr_ctrl_ready); end
    n_checks++; if (rd_chnl_valid !== 0 || wr_chnl_ready !== 0) begin n_errors++; $display("FAIL reset_chnl: got valid=%b ready=%b want 0 0", rd_chnl_valid, wr_chnl_ready); end
    n_checks++; if (busy !== 0 || err !== 0) begin n_errors++; $display("FAIL reset_busy_err: got %b %b want 0 0", busy, err); end
    n_checks++; if (debug !== 32'h0 || rd_chnl_data !== 64'h0) begin n_errors++; $display("FAIL reset_debug_data: got %h %h want 0 0", debug, rd_chnl_data); end
    rd_ctrl_valid = 0; wr_ctrl_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    m_err = 0; m_bursts = 0;
  endtask

  task automatic test_write_read();
    int hs, fr;
    bit to;
    for (int i = 0; i < 4; i++) wr_buf[i] = 64'(i + 1);
    do_ctrl(0, 32'd0, 32'd4, 3'b011, hs, to);
    wr_beats(4, 0, fr, to);
    n_checks++; if (to || fr != hs + 1) begin n_errors++; $display("FAIL wr_first_ready: got cycle %0d want %0d (timeout=%0d)", fr, hs + 1, to); end
    model_write(32'd0, 4);
    do_ctrl(1, 32'd0, 32'd4, 3'b011, hs, to);
    collect_rd(4, 0, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL wr_rd_timeout: got %0d beats want 4", rd_q.size()); end
    for (int i = 0; i < rd_q.size(); i++) begin
      n_checks++;
      if (rd_q[i] !== 64'(i + 1) || rd_cyc_q[i] != hs + 2 + i) begin
        n_errors++; $display("FAIL wr_rd_beat%0d: got %h@%0d want %h@%0d", i, rd_q[i], rd_cyc_q[i], 64'(i + 1), hs + 2 + i);
      end
    end
    @(negedge clk); #1;
    n_checks++; if (err !== 0 || debug[31:16] !== 16'd2 || busy !== 0) begin n_errors++; $display("FAIL wr_rd_status: got err=%b cnt=%0d busy=%b want 0 2 0", err, debug[31:16], busy); end
  endtask

  task automatic test_backpressure();
    int hs;
    bit to;
    do_ctrl(1, 32'd0, 32'd3, 3'b011, hs, to);
    collect_rd(3, 1, to);
    n_checks++; if (to || rd_q.size() != 3) begin n_errors++; $display("FAIL bp_count: got %0d beats want 3", rd_q.size()); end
    n_checks++; if (hold_err != 0) begin n_errors++; $display("FAIL bp_hold: got %0d hold violations want 0", hold_err); end
    for (int i = 0; i < rd_q.size(); i++) begin
      n_checks++; if (rd_q[i] !== m_mem[i]) begin n_errors++; $display("FAIL bp_data%0d: got %h want %h", i, rd_q[i], m_mem[i]); end
    end
    n_checks++; if (busy !== 1) begin n_errors++; $display("FAIL bp_busy_last: got %b want 1", busy); end
    @(negedge clk);
    rd_chnl_ready = 1;
    #1;
    n_checks++; if (busy !== 0 || rd_chnl_valid !== 0) begin n_errors++; $display("FAIL bp_busy_after: got busy=%b valid=%b want 0 0", busy, rd_chnl_valid); end
  endtask

  task automatic test_wrap_err();
    int hs, fr;
    bit to;
    for (int i = 0; i < 4; i++) wr_buf[i] = {$urandom, $urandom};
    n_checks++; if (err !== 0) begin n_errors++; $display("FAIL wrap_err_before: got %b want 0", err); end
    do_ctrl(0, 32'd1022, 32'd4, 3'b011, hs, to);
    wr_beats(4, 0, fr, to);
    model_write(32'd1022, 4);
    n_checks++; if (err !== 1) begin n_errors++; $display("FAIL wrap_err_after: got %b want 1", err); end
    do_ctrl(1, 32'd0, 32'd2, 3'b011, hs, to);
    collect_rd(2, 0, to);
    for (int i = 0; i < rd_q.size(); i++) begin
      n_checks++; if (rd_q[i] !== wr_buf[2 + i]) begin n_errors++; $display("FAIL wrap_low%0d: got %h want %h", i, rd_q[i], wr_buf[2 + i]); end
    end
    do_ctrl(1, 32'd1022, 32'd4, 3'b011, hs, to);
    collect_rd(4, 2, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL wrap_rd_timeout: got %0d beats want 4", rd_q.size()); end
    for (int i = 0; i < rd_q.size(); i++) begin
      n_checks++; if (rd_q[i] !== wr_buf[i]) begin n_errors++; $display("FAIL wrap_rd%0d: got %h want %h", i, rd_q[i], wr_buf[i]); end
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    int fr;
    bit to;
    apply_reset();
    @(negedge clk);
    rd_ctrl_valid = 1; rd_ctrl_index = 0;   rd_ctrl_length = 2; rd_ctrl_size = 3'b011;
    wr_ctrl_valid = 1; wr_ctrl_index = 300; wr_ctrl_length = 2; wr_ctrl_size = 3'b011;
    rd_chnl_ready = 1;
    #1;
    n_checks++; if (rd_ctrl_ready !== 1 || wr_ctrl_ready !== 0) begin n_errors++; $display("FAIL sim_first_grant: got rd=%b wr=%b want 1 0", rd_ctrl_ready, wr_ctrl_ready); end
    rd_q.delete();
    do begin
      @(negedge clk); #1;
      if (rd_chnl_valid && rd_chnl_ready) rd_q.push_back(rd_chnl_data);
      n++;
    end while (!(rd_ctrl_ready || wr_ctrl_ready) && n < 20);
    n_checks++; if (wr_ctrl_ready !== 1 || rd_ctrl_ready !== 0) begin n_errors++; $display("FAIL sim_second_grant: got rd=%b wr=%b want 0 1", rd_ctrl_ready, wr_ctrl_ready); end
    n_checks++; if (rd_q.size() != 2 || rd_q[0] !== m_mem[0] || rd_q[1] !== m_mem[1]) begin n_errors++; $display("FAIL sim_rd_data: got %0d beats want 2 matching model", rd_q.size()); end
    m_bursts = 16'd2;
    for (int i = 0; i < 2; i++) wr_buf[i] = {$urandom, $urandom};
    wr_beats(2, 0, fr, to);
    model_write(32'd300, 2);
    @(negedge clk); wr_chnl_valid = 0; #1;
    n_checks++; if (to || debug[31:16] !== m_bursts || busy !== 0) begin n_errors++; $display("FAIL sim_done: got cnt=%0d busy=%b want %0d 0", debug[31:16], busy, m_bursts); end
  endtask

  task automatic test_len0_size();
    int hs0, hs1, fr;
    bit to;
    apply_reset();
    do_ctrl(1, 32'd0, 32'd0, 3'b011, hs0, to);
    for (int i = 0; i < 2; i++) wr_buf[i] = {$urandom, $urandom};
    do_ctrl(0, 32'd10, 32'd2, 3'b010, hs1, to);
    n_checks++; if (to || hs1 != hs0 + 1) begin n_errors++; $display("FAIL len0_next_accept: got cycle %0d want %0d", hs1, hs0 + 1); end
    n_checks++; if (rd_chnl_valid !== 0) begin n_errors++; $display("FAIL len0_no_beat: got valid=%b want 0", rd_chnl_valid); end
    wr_beats(2, 0, fr, to);
    model_write(32'd10, 2);
    @(negedge clk); wr_chnl_valid = 0; #1;
    n_checks++; if (err !== 1 || debug[31:16] !== 16'd2) begin n_errors++; $display("FAIL size_err: got err=%b cnt=%0d want 1 2", err, debug[31:16]); end
    do_ctrl(1, 32'd10, 32'd2, 3'b011, hs0, to);
    collect_rd(2, 0, to);
    n_checks++; if (to || rd_q.size() != 2 || rd_q[0] !== wr_buf[0] || rd_q[1] !== wr_buf[1]) begin n_errors++; $display("FAIL size_served64: got %0d beats want 2 matching %h %h", rd_q.size(), wr_buf[0], wr_buf[1]); end
  endtask

  task automatic test_reset_midburst();
    int hs, fr;
    bit to;
    for (int i = 0; i < 8; i++) wr_buf[i] = {$urandom, $urandom};
    do_ctrl(0, 32'd200, 32'd8, 3'b011, hs, to);
    wr_beats(8, 0, fr, to);
    model_write(32'd200, 8);
    do_ctrl(1, 32'd200, 32'd8, 3'b011, hs, to);
    collect_rd(1, 0, to);
    @(negedge clk); #1;
    n_checks++; if (rd_chnl_valid !== 1 || rd_chnl_data !== m_mem[201] || debug[15:0] !== 16'd7) begin n_errors++; $display("FAIL mid_beat2: got v=%b d=%h left=%0d want 1 %h 7", rd_chnl_valid, rd_chnl_data, debug[15:0], m_mem[201]); end
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (rd_chnl_valid !== 0 || busy !== 0 || err !== 0 || debug !== 0 || rd_chnl_data !== 0) begin n_errors++; $display("FAIL mid_reset_vals: got v=%b busy=%b err=%b dbg=%h d=%h want all 0", rd_chnl_valid, busy, err, debug, rd_chnl_data); end
    n_checks++; if (rd_ctrl_ready !== 0 || wr_ctrl_ready !== 0 || wr_chnl_ready !== 0) begin n_errors++; $display("FAIL mid_reset_ready: got %b%b%b want 000", rd_ctrl_ready, wr_ctrl_ready, wr_chnl_ready); end
    rst = 1'b0;
    m_err = 0; m_bursts = 0;
    do_ctrl(1, 32'd203, 32'd1, 3'b011, hs, to);
    collect_rd(1, 0, to);
    n_checks++; if (to || rd_q.size() != 1 || rd_q[0] !== m_mem[203] || rd_cyc_q[0] != hs + 2) begin n_errors++; $display("FAIL mid_after: got %0d beats want 1 of %h at cycle %0d", rd_q.size(), m_mem[203], hs + 2); end
    @(negedge clk); #1;
    n_checks++; if (debug[31:16] !== 16'd1 || busy !== 0) begin n_errors++; $display("FAIL mid_after_status: got cnt=%0d busy=%b want 1 0", debug[31:16], busy); end
  endtask

  task automatic test_random();
    int hs, fr, len, a;
    bit to, is_rd;
    logic [31:0] idx;
    logic [2:0]  size;
    for (int it = 0; it < 40; it++) begin
      is_rd = (wr_starts.size() > 0) && ($urandom_range(0, 1) == 1);
      len = $urandom_range(1, 6);
      size = ($urandom_range(0, 7) == 0) ? 3'b111 : 3'b011;
      if (is_rd) begin
        idx = 32'(wr_starts[$urandom_range(0, wr_starts.size() - 1)]);
        do_ctrl(1, idx, 32'(len), size, hs, to);
        collect_rd(len, 2, to);
        n_checks++; if (to || hold_err != 0) begin n_errors++; $display("FAIL rnd_rd%0d: got beats=%0d holds=%0d want %0d 0", it, rd_q.size(), hold_err, len); end
        for (int i = 0; i < rd_q.size(); i++) begin
          a = waddr(idx, i);
          if (m_known[a]) begin
            n_checks++; if (rd_q[i] !== m_mem[a]) begin n_errors++; $display("FAIL rnd_data%0d_%0d: got %h want %h", it, i, rd_q[i], m_mem[a]); end
          end
        end
      end else begin
        idx = 32'($urandom_range(0, 1023));
        for (int i = 0; i < len; i++) wr_buf[i] = {$urandom, $urandom};
        do_ctrl(0, idx, 32'(len), size, hs, to);
        wr_beats(len, 1, fr, to);
        n_checks++; if (to) begin n_errors++; $display("FAIL rnd_wr%0d: got timeout want %0d beats", it, len); end
        model_write(idx, len);
        wr_starts.push_back(int'(idx));
      end
      @(negedge clk); wr_chnl_valid = 0; #1;
      n_checks++; if (err !== m_err || debug[31:16] !== m_bursts || busy !== 0) begin n_errors++; $display("FAIL rnd_status%0d: got err=%b cnt=%0d busy=%b want %b %0d 0", it, err, debug[31:16], busy, m_err, m_bursts); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) m_known[i] = 0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_wrap_err();
    test_simultaneous();
    test_len0_size();
    test_reset_midburst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
